// File: rtl/key_debounce_sync_pkg.sv
// key_debounce_sync_pkg: shared constants and helpers for the pushbutton conditioner
package key_debounce_sync_pkg;

    // 10 ms of stable level at a 50 MHz system clock
    localparam int DEFAULT_DEBOUNCE_50MHZ_10MS = 500000;

    // Number of bits needed to hold values 0 .. value-1
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/key_debounce_sync_if.sv
// key_debounce_sync_if: pad inputs and conditioned outputs of the pushbutton conditioner
interface key_debounce_sync_if #(
    parameter int WIDTH = 1
) ();

    logic [WIDTH-1:0] pad_in;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] edge_sticky;

    // Board/consumer side: drives pads and sticky clears, observes levels and edges
    modport master (
        output pad_in,
        output edge_clr,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse,
        input  edge_sticky
    );

    // Conditioner side
    modport slave (
        input  pad_in,
        input  edge_clr,
        output level_out,
        output rise_pulse,
        output fall_pulse,
        output edge_sticky
    );

endinterface

// File: rtl/key_debounce_sync_debounce_chan.sv
// key_debounce_sync_debounce_chan: one pad channel - synchroniser, debounce counter, edge pulses, sticky flag
module key_debounce_sync_debounce_chan
    import key_debounce_sync_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_50MHZ_10MS,
    parameter int SYNC_STAGES     = 2,
    parameter bit INVERT          = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pad_i,
    input  logic edge_clr_i,
    output logic level_o,
    output logic rise_pulse_o,
    output logic fall_pulse_o,
    output logic edge_sticky_o
);

    localparam int            CW    = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sticky_q, sticky_d;
    logic                   s;
    logic                   accept;

    // Synchroniser; resets to the released-pad level so nothing is accepted out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= {SYNC_STAGES{INVERT}};
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end

    assign s = sync_q[SYNC_STAGES-1] ^ INVERT;

    // Accept a new level after DEBOUNCE_CYCLES consecutive mismatching samples; any match restarts the count
    always_comb begin
        accept   = (s != level_q) && (cnt_q == C_MAX);
        cnt_d    = (s == level_q || accept) ? '0 : cnt_q + CW'(1);
        level_d  = accept ? s : level_q;
        rise_d   = accept && s;
        fall_d   = accept && !s;
        sticky_d = rise_q ? 1'b1 : (edge_clr_i ? 1'b0 : sticky_q);
    end

    // Debounce state, registered edge pulses and sticky flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
        end
    end

    assign level_o       = level_q;
    assign rise_pulse_o  = rise_q;
    assign fall_pulse_o  = fall_q;
    assign edge_sticky_o = sticky_q;

endmodule

// File: rtl/key_debounce_sync.sv
// key_debounce_sync: WIDTH independent pushbutton/switch conditioners feeding PIO inputs
module key_debounce_sync
    import key_debounce_sync_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_50MHZ_10MS,
    parameter int SYNC_STAGES     = 2,
    parameter bit INVERT          = 1'b1
) (
    input logic                clk,
    input logic                reset_n,
    key_debounce_sync_if.slave bus
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] sticky;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        key_debounce_sync_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .INVERT          (INVERT)
        ) u_debounce_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .pad_i         (bus.pad_in[i]),
            .edge_clr_i    (bus.edge_clr[i]),
            .level_o       (level[i]),
            .rise_pulse_o  (rise[i]),
            .fall_pulse_o  (fall[i]),
            .edge_sticky_o (sticky[i])
        );
    end

    assign bus.level_out   = level;
    assign bus.rise_pulse  = rise;
    assign bus.fall_pulse  = fall;
    assign bus.edge_sticky = sticky;

endmodule
